// File: rtl/fsm_cc8_param.sv
// -----------------------------------------------------------------------------
// fsm_cc8_param
//
// Ten-state cc8 control sequencer with a bounded wait in S6 (timeout error),
// a bounded jump-hold loop in S3 (hold error) and selectable output alignment.
// The state register is one-hot and is exported for debug.
//
// Parameters:
//   TMO_W    width of the S6 wait counter and of tmo_lim
//   JMP_MAX  max consecutive S3 cycles with jmp held before a forced exit to S0
//            (0 disables the limit)
//   OUT_LA   1: y registered from decode(next state), so it matches state_o
//            0: y registered from decode(state), so it lags state_o by a cycle
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   go       start / continue request
//   jmp      jump to S3 (highest priority except S0 without go)
//   sk       skip select, sk[0]=sk0, sk[1]=sk1
//   tmo_lim  S6 wait limit in cycles, 0 disables the timeout
//   y        outputs, y[0]=y1, y[1]=y2, y[2]=y3
//   state_o  one-hot current state, bit n = Sn
//   tmo_err  one-cycle pulse in the first S9 cycle after an S6 timeout
//   jmp_err  one-cycle pulse in the first S0 cycle after the S3 hold limit
// -----------------------------------------------------------------------------
module fsm_cc8_param #(
    parameter int unsigned TMO_W   = 8,
    parameter int unsigned JMP_MAX = 16,
    parameter bit          OUT_LA  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             jmp,
    input  logic [1:0]       sk,
    input  logic [TMO_W-1:0] tmo_lim,
    output logic [2:0]       y,
    output logic [9:0]       state_o,
    output logic             tmo_err,
    output logic             jmp_err
);

    typedef enum logic [9:0] {
        S0 = 10'b00_0000_0001,
        S1 = 10'b00_0000_0010,
        S2 = 10'b00_0000_0100,
        S3 = 10'b00_0000_1000,
        S4 = 10'b00_0001_0000,
        S5 = 10'b00_0010_0000,
        S6 = 10'b00_0100_0000,
        S7 = 10'b00_1000_0000,
        S8 = 10'b01_0000_0000,
        S9 = 10'b10_0000_0000
    } state_e;

    // Hold limit is reached on the JMP_MAX-th S3 cycle, i.e. when the
    // counter of already-completed S3 cycles equals JMP_MAX-1.
    localparam bit          HOLD_EN   = (JMP_MAX != 0);
    localparam logic [15:0] HOLD_LAST = 16'(JMP_MAX - 1);

    state_e           state_q, state_d;
    logic [2:0]       y_q, y_d;
    logic [TMO_W-1:0] wcnt_q, wcnt_d;
    logic [15:0]      hcnt_q, hcnt_d;
    logic             tmo_err_q, tmo_err_d;
    logic             jmp_err_q, jmp_err_d;

    logic [TMO_W:0]   wcnt_inc;
    logic             tmo_hit;
    logic             hold_last;

    // Output pattern listed as {y1,y2,y3}, returned in port order {y3,y2,y1}.
    function automatic logic [2:0] decode(input state_e s);
        logic y1, y2, y3;
        {y1, y2, y3} = 3'b000;
        case (s)
            S1:      {y1, y2, y3} = 3'b010;
            S3:      {y1, y2, y3} = 3'b110;
            S6, S9:  {y1, y2, y3} = 3'b111;
            S7:      {y1, y2, y3} = 3'b001;
            S8:      {y1, y2, y3} = 3'b011;
            default: {y1, y2, y3} = 3'b000;
        endcase
        return {y3, y2, y1};
    endfunction

    // Compare one bit wider than the counter so wcnt+1 can never wrap below
    // the limit; lowering tmo_lim under wcnt therefore fires immediately.
    assign wcnt_inc  = {1'b0, wcnt_q} + (TMO_W+1)'(1);
    assign tmo_hit   = (tmo_lim != '0) && (wcnt_inc >= {1'b0, tmo_lim});
    assign hold_last = HOLD_EN && (hcnt_q == HOLD_LAST);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d   = S0;
        tmo_err_d = 1'b0;
        jmp_err_d = 1'b0;

        case (state_q)
            S0: begin
                if (!go)      state_d = S0;
                else if (jmp) state_d = S3;
                else          state_d = S1;
            end
            S1: state_d = jmp ? S3 : S2;
            S2: state_d = jmp ? S3 : S9;
            S3: begin
                if (jmp && hold_last) begin
                    state_d   = S0;
                    jmp_err_d = 1'b1;
                end else if (jmp) begin
                    state_d = S3;
                end else begin
                    state_d = S4;
                end
            end
            S4: begin
                if (jmp)        state_d = S3;
                else if (sk[0]) state_d = S6;
                else            state_d = S5;
            end
            S5: begin
                if (jmp) begin
                    state_d = S3;
                end else begin
                    case (sk)
                        2'b00:   state_d = S6;
                        2'b01:   state_d = S7;
                        2'b10:   state_d = S8;
                        default: state_d = S9;
                    endcase
                end
            end
            S6: begin
                // go and jmp both outrank the timeout, so a collision is silent.
                if (jmp) begin
                    state_d = S3;
                end else if (go) begin
                    state_d = S7;
                end else if (tmo_hit) begin
                    state_d   = S9;
                    tmo_err_d = 1'b1;
                end else begin
                    state_d = S6;
                end
            end
            S7: state_d = jmp ? S3 : S8;
            S8: state_d = jmp ? S3 : S9;
            S9: state_d = jmp ? S3 : S0;
            // Any non-one-hot encoding, including all-zero, recovers to S0.
            default: state_d = S0;
        endcase

        // Counters run only while the machine stays in their state, so they
        // read zero on every entry.
        wcnt_d = '0;
        if (state_q == S6 && state_d == S6)
            wcnt_d = (wcnt_q == '1) ? wcnt_q : wcnt_inc[TMO_W-1:0];

        hcnt_d = '0;
        if (state_q == S3 && state_d == S3)
            hcnt_d = (hcnt_q == 16'hFFFF) ? hcnt_q : hcnt_q + 16'd1;

        y_d = OUT_LA ? decode(state_d) : decode(state_q);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= S0;
            y_q       <= 3'b000;
            wcnt_q    <= '0;
            hcnt_q    <= '0;
            tmo_err_q <= 1'b0;
            jmp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            wcnt_q    <= wcnt_d;
            hcnt_q    <= hcnt_d;
            tmo_err_q <= tmo_err_d;
            jmp_err_q <= jmp_err_d;
        end
    end

    assign state_o = state_q;
    assign y       = y_q;
    assign tmo_err = tmo_err_q;
    assign jmp_err = jmp_err_q;

endmodule
